bram_scan_checker: RTL and testbench

Sweep engine that drives the address/data ports of the block-RAM `memory` stage and consumes its registered read data. On command it optionally fills the RAM with a deterministic address pattern, then reads every word back and compares it against the same pattern, counting mismatching words. Each checked word is rewritten with its golden value in the same cycle, so a CHECK pass also scrubs the array. It sits directly in front of the memory: its `raddr`/`waddr`/`din` feed the memory, and the memory's `douta` returns here.

---
 rtl/bram_scan_checker_if.sv | 37 +++
 rtl/bram_scan_checker.sv | 145 ++++++++++++++
 tb/tb_bram_scan_checker.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/bram_scan_checker_if.sv
// ---------------------------------------------------------------------------
// bram_scan_checker_if
// Bundles the command/status and memory-side signals of bram_scan_checker.
//   master : the checker (drives memory address/data and status)
//   slave  : the environment (command source + block RAM read data)
// Signals: start, fill_first (command); raddr, waddr, din, douta (memory);
//          busy, done, pass, err_cnt, first_err_addr, first_err_data (status)
// ---------------------------------------------------------------------------
interface bram_scan_checker_if #(
   parameter int WID_MEM = 64,
   parameter int ADDR_W  = 10
);
   logic                start;
   logic                fill_first;
   logic [ADDR_W-1:0]   raddr;
   logic [ADDR_W-1:0]   waddr;
   logic [WID_MEM-1:0]  din;
   logic [WID_MEM-1:0]  douta;
   logic                busy;
   logic                done;
   logic                pass;
   logic [15:0]         err_cnt;
   logic [ADDR_W-1:0]   first_err_addr;
   logic [WID_MEM-1:0]  first_err_data;

   modport master (
      input  start, fill_first, douta,
      output raddr, waddr, din, busy, done, pass, err_cnt,
             first_err_addr, first_err_data
   );

   modport slave (
      output start, fill_first, douta,
      input  raddr, waddr, din, busy, done, pass, err_cnt,
             first_err_addr, first_err_data
   );
endinterface

// File: rtl/bram_scan_checker.sv
// ---------------------------------------------------------------------------
// bram_scan_checker
// Sweeps a block RAM: optional FILL with pat(a) = SEED ^ a, then CHECK that
// reads every word, counts mismatches and rewrites the golden value in the
// same cycle (scrub).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   bus   - bram_scan_checker_if.master (command, memory port, status)
// Optional build macro: SCAN_FIRST_ERR_LOG_EN enables the first-error log
// (first_err_addr / first_err_data); without it both are tied to 0.
// ---------------------------------------------------------------------------
module bram_scan_checker #(
   parameter int          WID_MEM   = 64,
   parameter int          DEPTH_MEM = 512,
   parameter int          ADDR_W    = 10,
   parameter logic [63:0] SEED      = 64'hA5A5_5A5A_0F0F_F0F0
) (
   input  logic                 clk,
   input  logic                 reset,
   bram_scan_checker_if.master  bus
);

   localparam logic [ADDR_W-1:0]  LAST   = ADDR_W'(DEPTH_MEM - 1);
   localparam logic [WID_MEM-1:0] SEED_W = SEED[WID_MEM-1:0];

   function automatic logic [WID_MEM-1:0] pat(input logic [ADDR_W-1:0] a);
      return SEED_W ^ WID_MEM'(a);
   endfunction

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_CHECK, S_DRAIN, S_DONE} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   addr;
   logic [WID_MEM-1:0]  din_q;
   logic                busy_q, done_q, pass_q;
   logic [15:0]         err_q;
   // One-cycle delayed view of the CHECK sweep, aligned with douta.
   logic                chk_vld;
   logic [WID_MEM-1:0]  chk_exp;

   logic                accept, mism;
   logic [15:0]         err_nxt;

   always_comb begin
      accept  = (state == S_IDLE) && bus.start;
      mism    = chk_vld && (bus.douta != chk_exp);
      err_nxt = err_q;
      if (mism && (err_q != 16'hFFFF))
         err_nxt = err_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         addr    <= '0;
         din_q   <= pat('0);
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b1;
         err_q   <= '0;
         chk_vld <= 1'b0;
         chk_exp <= '0;
      end else begin
         chk_vld <= (state == S_CHECK);
         chk_exp <= din_q;
         err_q   <= err_nxt;
         done_q  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  err_q  <= '0;
                  busy_q <= 1'b1;
                  state  <= bus.fill_first ? S_FILL : S_CHECK;
               end
            end
            S_FILL, S_CHECK: begin
               if (addr == LAST) begin
                  // Address returns to 0 so DRAIN/IDLE drive pat(0) at addr 0.
                  state <= (state == S_FILL) ? S_CHECK : S_DRAIN;
                  addr  <= '0;
                  din_q <= pat('0);
               end else begin
                  addr  <= addr + 1'b1;
                  din_q <= pat(addr + 1'b1);
               end
            end
            S_DRAIN: begin
               // err_nxt already includes the last word's comparison.
               state  <= S_DONE;
               done_q <= 1'b1;
               pass_q <= (err_nxt == 16'd0);
            end
            S_DONE: begin
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.raddr   = addr;
   assign bus.waddr   = addr;
   assign bus.din     = din_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.pass    = pass_q;
   assign bus.err_cnt = err_q;

`ifdef SCAN_FIRST_ERR_LOG_EN
   logic                log_vld;
   logic [ADDR_W-1:0]   chk_addr, log_addr;
   logic [WID_MEM-1:0]  log_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         log_vld  <= 1'b0;
         chk_addr <= '0;
         log_addr <= '0;
         log_data <= '0;
      end else begin
         chk_addr <= addr;
         if (accept) begin
            log_vld  <= 1'b0;
            log_addr <= '0;
            log_data <= '0;
         end else if (mism && !log_vld) begin
            log_vld  <= 1'b1;
            log_addr <= chk_addr;
            log_data <= bus.douta;
         end
      end
   end

   assign bus.first_err_addr = log_addr;
   assign bus.first_err_data = log_data;
`else
   logic unused_accept;
   assign unused_accept      = accept;
   assign bus.first_err_addr = '0;
   assign bus.first_err_data = '0;
`endif

endmodule

// File: tb/tb_bram_scan_checker.sv
module tb_bram_scan_checker;
   localparam int          DEPTH = 512;
   localparam logic [63:0] SEED  = 64'hA5A5_5A5A_0F0F_F0F0;
`ifdef SCAN_FIRST_ERR_LOG_EN
   localparam bit LOG = 1'b1;
`else
   localparam bit LOG = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rst2 = 1'b1;
   always #5 clk = ~clk;

   bram_scan_checker_if #(.WID_MEM(64), .ADDR_W(10)) bus ();
   bram_scan_checker_if #(.WID_MEM(32), .ADDR_W(17)) bus2 ();

   bram_scan_checker #(.WID_MEM(64), .DEPTH_MEM(DEPTH), .ADDR_W(10), .SEED(SEED))
      dut (.clk(clk), .reset(reset), .bus(bus));

   // Large-depth instance against an all-zero RAM to reach counter saturation.
   bram_scan_checker #(.WID_MEM(32), .DEPTH_MEM(65540), .ADDR_W(17), .SEED(SEED))
      dut2 (.clk(clk), .reset(rst2), .bus(bus2));

   // Read-before-write RAM that writes every cycle, plus a bench write port.
   logic [63:0] mem [1024];
   logic        inj_en = 1'b0;
   logic [9:0]  inj_addr = '0;
   logic [63:0] inj_data = '0;
   always @(posedge clk) begin
      bus.douta <= mem[bus.raddr];
      mem[bus.waddr] <= bus.din;
      if (inj_en) mem[inj_addr] <= inj_data;
   end

   // Every read of the zero-loaded RAM returns 0 within a single pass.
   always @(posedge clk) bus2.douta <= '0;

   int checks = 0;
   int failures = 0;

   function automatic logic [63:0] gold(input int a);
      return SEED ^ 64'(a);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic inject(input int a, input logic [63:0] d);
      @(negedge clk);
      inj_en = 1'b1; inj_addr = 10'(a); inj_data = d;
      @(negedge clk);
      inj_en = 1'b0;
   endtask

   // Expected outcome of a CHECK pass from the current RAM image.
   task automatic model(output int cnt, output int fa, output logic [63:0] fd);
      cnt = 0; fa = 0; fd = '0;
      for (int a = 0; a < DEPTH; a++) begin
         if (mem[a] !== gold(a)) begin
            if (cnt == 0) begin fa = a; fd = mem[a]; end
            if (cnt < 65535) cnt++;
         end
      end
   endtask

   task automatic bad_words(output int n);
      n = 0;
      for (int a = 0; a < DEPTH; a++) if (mem[a] !== gold(a)) n++;
   endtask

   // Pulses start and returns the cycle index at which done is seen.
   task automatic run_pass(input logic ff, output int lat);
      @(negedge clk);
      bus.start = 1'b1; bus.fill_first = ff;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 3000) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_pass(input string tag, input int lat, input int exp_lat);
      int cnt, fa, n;
      logic [63:0] fd;
      cnt = 0; fa = 0; fd = '0;
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
   endtask

   initial begin
      int lat, cnt, fa, n, k, dn;
      logic [63:0] fd;
      bus.start = 1'b0; bus.fill_first = 1'b0;
      bus2.start = 1'b0; bus2.fill_first = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_raddr", 64'(bus.raddr), 64'd0);
      chk("rst_waddr", 64'(bus.waddr), 64'd0);
      chk("rst_din", bus.din, gold(0));
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_pass", 64'(bus.pass), 64'd1);
      chk("rst_err", 64'(bus.err_cnt), 64'd0);
      chk("rst_fea", 64'(bus.first_err_addr), 64'd0);
      chk("rst_fed", bus.first_err_data, 64'd0);
      reset = 1'b0; rst2 = 1'b0;

      // Kick off the saturation run; it proceeds in the background.
      @(negedge clk);
      bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      chk("sat_busy_on", 64'(bus2.busy), 64'd1);

      // Fill + check on an unknown RAM.
      run_pass(1'b1, lat);
      chk("fill_lat", 64'(lat), 64'd1026);
      chk("fill_pass", 64'(bus.pass), 64'd1);
      chk("fill_err", 64'(bus.err_cnt), 64'd0);
      @(negedge clk);
      bad_words(n);
      chk("fill_image", 64'(n), 64'd0);

      // Directed fault injection.
      inject(37, ~gold(37));
      inject(300, gold(300) ^ 64'd1);
      run_pass(1'b0, lat);
      chk("flt_lat", 64'(lat), 64'd514);
      chk("flt_err", 64'(bus.err_cnt), 64'd2);
      chk("flt_pass", 64'(bus.pass), 64'd0);
      chk("flt_fea", 64'(bus.first_err_addr), LOG ? 64'd37 : 64'd0);
      chk("flt_fed", bus.first_err_data, LOG ? ~gold(37) : 64'd0);
      @(negedge clk);
      run_pass(1'b0, lat);
      chk("scrub_err", 64'(bus.err_cnt), 64'd0);
      chk("scrub_pass", 64'(bus.pass), 64'd1);
      chk("scrub_fea", 64'(bus.first_err_addr), 64'd0);
      @(negedge clk);

      // Randomized fault sets against the array model.
      for (int it = 0; it < 3; it++) begin
         k = $urandom_range(1, 12);
         for (int j = 0; j < k; j++)
            inject($urandom_range(1, DEPTH - 1), {$urandom, $urandom});
         @(negedge clk);
         model(cnt, fa, fd);
         run_pass(1'b0, lat);
         chk("rnd_lat", 64'(lat), 64'd514);
         chk("rnd_err", 64'(bus.err_cnt), 64'(cnt));
         chk("rnd_pass", 64'(bus.pass), 64'(cnt == 0));
         chk("rnd_fea", 64'(bus.first_err_addr), LOG ? 64'(fa) : 64'd0);
         chk("rnd_fed", bus.first_err_data, LOG ? fd : 64'd0);
         @(negedge clk);
         bad_words(n);
         chk("rnd_image", 64'(n), 64'd0);
      end

      // start pulses during CHECK and in the done cycle are ignored.
      @(negedge clk);
      bus.start = 1'b1; bus.fill_first = 1'b0;
      @(negedge clk);
      lat = 1;
      while (!bus.done && lat < 3000) begin
         bus.start = (lat == 100);
         @(negedge clk);
         lat++;
      end
      chk("ign_lat", 64'(lat), 64'd514);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      dn = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (bus.done) dn++;
      end
      chk("ign_busy", 64'(bus.busy), 64'd0);
      chk("ign_dones", 64'(dn), 64'd0);

      // Reset abort at address 200 of CHECK.
      inject(10, 64'd0);
      inject(400, 64'd1);
      @(negedge clk);
      bus.start = 1'b1; bus.fill_first = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (bus.raddr != 10'd200 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("abort_pre_err", 64'(bus.err_cnt), 64'd1);
      reset = 1'b1;
      #1;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_raddr", 64'(bus.raddr), 64'd0);
      chk("abort_err", 64'(bus.err_cnt), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      dn = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (bus.done) dn++;
      end
      chk("abort_dones", 64'(dn), 64'd0);
      model(cnt, fa, fd);
      run_pass(1'b0, lat);
      chk("after_lat", 64'(lat), 64'd514);
      chk("after_err", 64'(bus.err_cnt), 64'(cnt));
      chk("after_pass", 64'(bus.pass), 64'(cnt == 0));

      // Saturation result.
      n = 0;
      while (bus2.busy && n < 80000) begin
         @(negedge clk);
         n++;
      end
      chk("sat_busy_off", 64'(bus2.busy), 64'd0);
      chk("sat_err", 64'(bus2.err_cnt), 64'hFFFF);
      chk("sat_pass", 64'(bus2.pass), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
